imem_program_loader: RTL

- Hardware replacement for the bench-side instruction preload; sits directly upstream of the fetch stage's halfword instruction memory.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and splits each into two 16-bit IMEM writes (low half at even address, high half at odd address).
- Zero-pads the image to a fixed word count, then releases the core's reset and runs a fixed drain window before flagging done.

---
 rtl/imem_program_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Accepts 32-bit instruction words over valid/ready, writes each as two
// halfwords into IMEM, zero-pads the image to NUM_WORDS words, then releases
// the core reset and runs a fixed drain window before reporting done.
// NUM_WORDS must satisfy 2*NUM_WORDS <= 2**IMEM_AW; RST_HOLD and DRAIN_CYCLES must be >= 1.
module imem_program_loader #(
  parameter int unsigned IMEM_AW      = 10,
  parameter int unsigned NUM_WORDS    = 200,
  parameter int unsigned RST_HOLD     = 2,
  parameter int unsigned DRAIN_CYCLES = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_wr_valid,
  input  logic [31:0]        i_wr_data,
  input  logic               i_wr_last,
  output logic               o_wr_ready,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [15:0]        o_imem_wdata,
  output logic               o_core_n_rst,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_trunc,
  output logic [15:0]        o_word_cnt
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TMR_MAX = (RST_HOLD > DRAIN_CYCLES) ? RST_HOLD : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLD,
    S_LOAD,
    S_WR_LO,
    S_WR_HI,
    S_PAD_LO,
    S_PAD_HI,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [TMR_W-1:0]   timer;
  logic [15:0]        word_hi_q;
  logic               last_q;
  logic [CNT_W-1:0]   cnt_inc_c;
  logic [IMEM_AW-1:0] addr_lo_c;
  logic [IMEM_AW-1:0] addr_hi_c;
  logic [IMEM_AW-1:0] addr_next_lo_c;

  // Halfword addresses for the current word and the word after it
  assign cnt_inc_c      = o_word_cnt + CNT_W'(1);
  assign addr_lo_c      = IMEM_AW'({o_word_cnt, 1'b0});
  assign addr_hi_c      = IMEM_AW'({o_word_cnt, 1'b1});
  assign addr_next_lo_c = IMEM_AW'({cnt_inc_c, 1'b0});

  // Loader FSM; every output is registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      word_hi_q    <= '0;
      last_q       <= 1'b0;
      o_wr_ready   <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_core_n_rst <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_trunc      <= 1'b0;
      o_word_cnt   <= '0;
    end else begin
      o_wr_ready <= 1'b0;
      o_imem_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (i_start) begin
            state      <= S_HOLD;
            o_busy     <= 1'b1;
            o_trunc    <= 1'b0;
            o_word_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (timer == TMR_W'(RST_HOLD - 1)) begin
            timer      <= '0;
            state      <= S_LOAD;
            o_wr_ready <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_LOAD: begin
          if (i_wr_valid && o_wr_ready) begin
            word_hi_q    <= i_wr_data[31:16];
            last_q       <= i_wr_last;
            state        <= S_WR_LO;
            o_imem_we    <= 1'b1;
            o_imem_addr  <= addr_lo_c;
            o_imem_wdata <= i_wr_data[15:0];
          end else begin
            o_wr_ready <= 1'b1;
          end
        end
        S_WR_LO: begin
          state        <= S_WR_HI;
          o_imem_we    <= 1'b1;
          o_imem_addr  <= addr_hi_c;
          o_imem_wdata <= word_hi_q;
        end
        S_PAD_LO: begin
          state        <= S_PAD_HI;
          o_imem_we    <= 1'b1;
          o_imem_addr  <= addr_hi_c;
          o_imem_wdata <= 16'h0000;
        end
        S_WR_HI, S_PAD_HI: begin
          o_word_cnt <= cnt_inc_c;
          if (cnt_inc_c == CNT_W'(NUM_WORDS)) begin
            state        <= S_RUN;
            timer        <= '0;
            o_core_n_rst <= 1'b1;
            if (!last_q) o_trunc <= 1'b1;
          end else if (last_q) begin
            state        <= S_PAD_LO;
            o_imem_we    <= 1'b1;
            o_imem_addr  <= addr_next_lo_c;
            o_imem_wdata <= 16'h0000;
          end else begin
            state      <= S_LOAD;
            o_wr_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (timer == TMR_W'(DRAIN_CYCLES - 1)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_DONE: begin
          timer <= '0;
          if (i_start) begin
            state        <= S_HOLD;
            o_core_n_rst <= 1'b0;
            o_done       <= 1'b0;
            o_busy       <= 1'b1;
            o_trunc      <= 1'b0;
            o_word_cnt   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
